// File: rtl/sp_types_pkg.sv
// Shared scratchpad types: request/response FIFO entries and bank geometry.
package sp_types_pkg;

    localparam int unsigned BITS_PER_ROW = 64;
    localparam int unsigned MAT_S_W      = 4;
    localparam int unsigned ROW_S_W      = 2;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned MAT_T_W      = 2;
    localparam int unsigned SP_ROW_AW    = MAT_S_W + ROW_S_W;

    // mat_t value that routes a read to the DRAM store path
    localparam logic [MAT_T_W-1:0] MAT_T_STORE = 2'b00;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [MAT_T_W-1:0] mat_t;
        logic [MAT_S_W-1:0] mat_s;
        logic [ROW_S_W-1:0] row_s;
    } rFIFO_t;

    typedef struct packed {
        logic [MAT_S_W-1:0]      mat_s;
        logic [ROW_S_W-1:0]      row_s;
        logic [BITS_PER_ROW-1:0] data;
    } wFIFO_t;

    typedef struct packed {
        logic [ADDR_W-1:0]       addr;
        logic [MAT_S_W-1:0]      mat_s;
        logic [ROW_S_W-1:0]      row_s;
        logic [BITS_PER_ROW-1:0] data;
    } dramFIFO_t;

    typedef struct packed {
        logic [MAT_T_W-1:0]      mat_t;
        logic [MAT_S_W-1:0]      mat_s;
        logic [ROW_S_W-1:0]      row_s;
        logic [BITS_PER_ROW-1:0] data;
    } gemmFIFO_t;

    function automatic logic [SP_ROW_AW-1:0] row_addr(input rFIFO_t r);
        return {r.mat_s, r.row_s};
    endfunction

endpackage

// File: rtl/sp_resp_skid.sv
// Response register for a 1-cycle-latency memory read: holds the request and
// keeps the returned row alive while the consumer is not ready.
module sp_resp_skid #(
    parameter int unsigned REQ_W  = 40,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [REQ_W-1:0]  load_req,
    input  logic              ready,
    input  logic [DATA_W-1:0] rdata,
    output logic              valid,
    output logic [REQ_W-1:0]  req,
    output logic [DATA_W-1:0] row,
    output logic              drain
);

    logic              fresh;
    logic [DATA_W-1:0] data;

    assign drain = valid & ready;
    // Memory output is only valid the cycle after the read; afterwards use the copy.
    assign row   = fresh ? rdata : data;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            fresh <= 1'b0;
            data  <= '0;
            req   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            req   <= load_req;
            fresh <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
            fresh <= 1'b0;
        end else if (fresh) begin
            data  <= rdata;
            fresh <= 1'b0;
        end
    end

endmodule

// File: rtl/sp_read_responder.sv
// Read side of one scratchpad bank: issues SRAM reads from the request FIFO
// and routes each returned row to the DRAM store or GEMM operand FIFO in order.
module sp_read_responder
    import sp_types_pkg::*;
#(
    parameter int unsigned SRAM_AW = SP_ROW_AW
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    rfifo_empty,
    input  rFIFO_t                  rfifo_rdata,
    output logic                    rfifo_ren,
    input  logic                    wr_active,
    output logic                    sram_ren,
    output logic [SRAM_AW-1:0]      sram_raddr,
    input  logic [BITS_PER_ROW-1:0] sram_rdata,
    input  logic                    dram_full,
    output logic                    dram_wen,
    output dramFIFO_t               dram_wdata,
    input  logic                    gemm_full,
    output logic                    gemm_wen,
    output gemmFIFO_t               gemm_wdata,
    output logic                    idle
);

    logic [$bits(rFIFO_t)-1:0] s1_req_bits;
    rFIFO_t                    s1_req;
    logic                      s1_valid;
    logic                      drain;
    logic                      is_store;
    logic                      tgt_full;
    logic                      issue;
    logic [BITS_PER_ROW-1:0]   row;

    assign s1_req   = s1_req_bits;
    assign is_store = (s1_req.mat_t == MAT_T_STORE);
    // A full target blocks both paths so responses leave strictly in order.
    assign tgt_full = is_store ? dram_full : gemm_full;
    assign issue    = ~RST & ~rfifo_empty & ~wr_active & (~s1_valid | drain);

    sp_resp_skid #(
        .REQ_W  ($bits(rFIFO_t)),
        .DATA_W (BITS_PER_ROW)
    ) u_skid (
        .clk      (CLK),
        .rst      (RST),
        .load     (issue),
        .load_req (rfifo_rdata),
        .ready    (~tgt_full),
        .rdata    (sram_rdata),
        .valid    (s1_valid),
        .req      (s1_req_bits),
        .row      (row),
        .drain    (drain)
    );

    assign rfifo_ren  = issue;
    assign sram_ren   = issue;
    assign sram_raddr = SRAM_AW'(row_addr(rfifo_rdata));

    assign dram_wen = ~RST & drain & is_store;
    assign gemm_wen = ~RST & drain & ~is_store;

    always_comb begin
        dram_wdata       = '0;
        dram_wdata.addr  = s1_req.addr;
        dram_wdata.mat_s = s1_req.mat_s;
        dram_wdata.row_s = s1_req.row_s;
        dram_wdata.data  = row;
        gemm_wdata       = '0;
        gemm_wdata.mat_t = s1_req.mat_t;
        gemm_wdata.mat_s = s1_req.mat_s;
        gemm_wdata.row_s = s1_req.row_s;
        gemm_wdata.data  = row;
    end

    assign idle = RST | ~s1_valid;

endmodule
